// File: rtl/opsum_requant_packer_pkg.sv
// Shared PE-array post-processing types: datapath widths, zero point, packer FSM states, requant config.
// Constants only; no logic.
package pe_pkg;

   localparam int DATA_BITS      = 32;
   localparam int CFG_SHIFT_BITS = 5;
   localparam int ZERO_POINT     = 128;

   typedef enum logic [1:0] {
      IDLE,
      FILL,
      OUT
   } state_e;

   typedef struct packed {
      logic [CFG_SHIFT_BITS-1:0] shift;
      logic                      relu;
   } requant_cfg_t;

endpackage

// File: rtl/opsum_requant_packer_requant.sv
// Combinational requant: optional ReLU, round-half-up arithmetic shift, +zero point, clamp to u8.
// Zero latency; no flow control.
module requant_u8
   import pe_pkg::ZERO_POINT;
#(
   parameter int DATA_BITS  = 32,
   parameter int SHIFT_BITS = 5
) (
   input  logic [DATA_BITS-1:0]  opsum_i,
   input  logic [SHIFT_BITS-1:0] shift_i,
   input  logic                  relu_i,
   output logic [7:0]            y_o
);

   // Two guard bits: the rounding add and the zero-point add can never overflow.
   localparam int W = DATA_BITS + 2;

   logic signed [W-1:0] x;
   logic signed [W-1:0] rnd;
   logic signed [W-1:0] r;
   logic signed [W-1:0] z;

   always_comb begin
      x = {{2{opsum_i[DATA_BITS-1]}}, opsum_i};
      if (relu_i && opsum_i[DATA_BITS-1]) x = '0;
      rnd = '0;
      if (shift_i != '0) rnd = W'(1) << (shift_i - 1'b1);
      r = (x + rnd) >>> shift_i;
      z = r + W'(ZERO_POINT);
      if (z[W-1])             y_o = 8'h00;
      else if (z > W'(255))   y_o = 8'hFF;
      else                    y_o = z[7:0];
   end

endmodule

// File: rtl/opsum_requant_packer.sv
// Requantizes PE opsums to u8 and packs four per little-endian word; 2-cycle latency (S1 + packer).
// Stalls only in OUT: S1 keeps one byte and opsum_ready drops until the word is taken.
module opsum_requant_packer
   import pe_pkg::state_e, pe_pkg::IDLE, pe_pkg::FILL, pe_pkg::OUT;
   import pe_pkg::requant_cfg_t, pe_pkg::CFG_SHIFT_BITS;
#(
   parameter int DATA_BITS  = 32,
   parameter int SHIFT_BITS = 5
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  cfg_load,
   input  logic [SHIFT_BITS-1:0] cfg_shift,
   input  logic                  cfg_relu,
   input  logic [DATA_BITS-1:0]  opsum,
   input  logic                  opsum_valid,
   input  logic                  opsum_last,
   output logic                  opsum_ready,
   output logic [DATA_BITS-1:0]  ofmap,
   output logic                  ofmap_valid,
   output logic                  ofmap_last,
   input  logic                  ofmap_ready
);

   localparam int LANES = DATA_BITS / 8;
   localparam int CW    = $clog2(LANES);
   localparam logic [DATA_BITS-1:0] PAD = {LANES{8'h80}};

   state_e               state_q, state_d;
   requant_cfg_t         cfg_q;
   logic                 s1_valid_q, s1_last_q;
   logic [7:0]           s1_y_q;
   logic [7:0]           y;
   logic [CW-1:0]        cnt_q, cnt_d, base_cnt;
   logic [DATA_BITS-1:0] word_q, word_d;
   logic                 last_q, last_d;
   logic                 s1_moves, in_xfer, out_xfer, wr, done;

   requant_u8 #(
      .DATA_BITS  (DATA_BITS),
      .SHIFT_BITS (CFG_SHIFT_BITS)
   ) u_requant (
      .opsum_i (opsum),
      .shift_i (cfg_q.shift),
      .relu_i  (cfg_q.relu),
      .y_o     (y)
   );

   assign s1_moves    = (state_q != OUT) || ofmap_ready;
   assign opsum_ready = !s1_valid_q || s1_moves;
   assign in_xfer     = opsum_valid && opsum_ready;
   assign out_xfer    = (state_q == OUT) && ofmap_ready;
   assign wr          = s1_valid_q && s1_moves;
   // A word leaving this edge frees the packer, so the S1 byte lands in lane 0 of a fresh word.
   assign base_cnt    = out_xfer ? '0 : cnt_q;
   assign done        = (base_cnt == CW'(LANES - 1)) || s1_last_q;

   assign ofmap       = word_q;
   assign ofmap_valid = (state_q == OUT);
   assign ofmap_last  = last_q;

   always_comb begin
      word_d  = out_xfer ? PAD : word_q;
      cnt_d   = base_cnt;
      last_d  = out_xfer ? 1'b0 : last_q;
      state_d = state_q;
      if (wr) begin
         word_d[{base_cnt, 3'b000} +: 8] = s1_y_q;
         cnt_d   = done ? '0 : base_cnt + 1'b1;
         last_d  = s1_last_q;
         state_d = done ? OUT : FILL;
      end else if (out_xfer || state_q == IDLE) begin
         state_d = in_xfer ? FILL : IDLE;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= IDLE;
         cfg_q      <= '0;
         s1_valid_q <= 1'b0;
         s1_last_q  <= 1'b0;
         s1_y_q     <= 8'h80;
         cnt_q      <= '0;
         word_q     <= PAD;
         last_q     <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         word_q  <= word_d;
         last_q  <= last_d;
         if (cfg_load && state_q == IDLE) begin
            cfg_q.shift <= cfg_shift;
            cfg_q.relu  <= cfg_relu;
         end
         if (opsum_ready) begin
            s1_valid_q <= opsum_valid;
            if (opsum_valid) begin
               s1_y_q    <= y;
               s1_last_q <= opsum_last;
            end
         end
      end
   end

endmodule

// File: tb/tb_opsum_requant_packer.sv
// Directed bench for opsum_requant_packer: stimulus pushes expected words, a negedge monitor pops and compares.
module tb_opsum_requant_packer;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        cfg_load = 1'b0;
   logic [4:0]  cfg_shift = '0;
   logic        cfg_relu = 1'b0;
   logic [31:0] opsum = '0;
   logic        opsum_valid = 1'b0;
   logic        opsum_last = 1'b0;
   logic        opsum_ready;
   logic [31:0] ofmap;
   logic        ofmap_valid;
   logic        ofmap_last;
   logic        ofmap_ready = 1'b1;

   typedef struct {
      logic [31:0] w;
      logic        l;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;
   int   waits  = 0;
   int   w0     = 0;

   opsum_requant_packer #(
      .DATA_BITS  (32),
      .SHIFT_BITS (5)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .cfg_load    (cfg_load),
      .cfg_shift   (cfg_shift),
      .cfg_relu    (cfg_relu),
      .opsum       (opsum),
      .opsum_valid (opsum_valid),
      .opsum_last  (opsum_last),
      .opsum_ready (opsum_ready),
      .ofmap       (ofmap),
      .ofmap_valid (ofmap_valid),
      .ofmap_last  (ofmap_last),
      .ofmap_ready (ofmap_ready)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, req);
      end
   endtask

   task automatic expect_word(input logic [31:0] w, input logic l);
      exp_t e;
      e.w = w;
      e.l = l;
      sb.push_back(e);
   endtask

   task automatic send(input logic [31:0] v, input logic l);
      int t = 0;
      opsum       = v;
      opsum_last  = l;
      opsum_valid = 1'b1;
      @(negedge clk);
      while (!opsum_ready && t < 200) begin
         @(negedge clk);
         t++;
         waits++;
      end
      if (!opsum_ready) begin
         checks++;
         errors++;
         $display("FAIL send_timeout actual=stalled required=accepted");
      end
      @(posedge clk);
      #1;
      opsum_valid = 1'b0;
      opsum_last  = 1'b0;
   endtask

   task automatic drain();
      int t = 0;
      while ((sb.size() != 0 || ofmap_valid) && t < 200) begin
         @(negedge clk);
         t++;
      end
      if (t >= 200) begin
         checks++;
         errors++;
         $display("FAIL drain_timeout actual=%0d_pending required=0", sb.size());
      end
      repeat (2) @(posedge clk);
      #1;
   endtask

   task automatic load_cfg(input logic [4:0] s, input logic r);
      @(posedge clk);
      #1;
      cfg_shift = s;
      cfg_relu  = r;
      cfg_load  = 1'b1;
      @(posedge clk);
      #1;
      cfg_load  = 1'b0;
   endtask

   // Monitor: one pop per output transfer.
   always @(negedge clk) begin
      if (rst && ofmap_valid && ofmap_ready) begin
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_word actual=%h required=none", ofmap);
         end else begin
            exp_t e;
            e = sb.pop_front();
            chk("ofmap", ofmap, e.w);
            chk("ofmap_last", {31'b0, ofmap_last}, {31'b0, e.l});
         end
      end
   end

   initial begin
      #1 rst = 1'b0;
      #2;
      chk("rst_opsum_ready", {31'b0, opsum_ready}, 32'd1);
      chk("rst_ofmap_valid", {31'b0, ofmap_valid}, 32'd0);
      chk("rst_ofmap_last",  {31'b0, ofmap_last},  32'd0);
      chk("rst_ofmap",       ofmap,                32'h80808080);
      @(posedge clk);
      #1 rst = 1'b1;

      // Shift 0, clamp high, and 2-cycle latency from the completing transfer.
      expect_word(32'hFF7F8180, 1'b0);
      send(32'd0, 1'b0);
      send(32'd1, 1'b0);
      send(-32'sd1, 1'b0);
      send(32'd200, 1'b0);
      @(negedge clk);
      chk("latency_edge_k", {31'b0, ofmap_valid}, 32'd0);
      @(negedge clk);
      chk("latency_edge_k1", {31'b0, ofmap_valid}, 32'd1);
      drain();

      // Shift 4 with rounding and clamp low.
      load_cfg(5'd4, 1'b0);
      expect_word(32'h00817F82, 1'b0);
      send(32'd24, 1'b0);
      send(-32'sd24, 1'b0);
      send(32'd8, 1'b0);
      send(-32'sd10000, 1'b0);
      drain();

      // Single-byte flush, padded lanes.
      expect_word(32'h80808042, 1'b1);
      send(-32'sd1000, 1'b1);
      drain();

      // ReLU with last on lane 1.
      load_cfg(5'd0, 1'b1);
      expect_word(32'h80808380, 1'b1);
      send(-32'sd5, 1'b0);
      send(32'd3, 1'b1);
      drain();

      // Last on lane 3: exactly one word.
      expect_word(32'h80898085, 1'b1);
      send(32'd5, 1'b0);
      send(-32'sd7, 1'b0);
      send(32'd9, 1'b0);
      send(-32'sd1, 1'b1);
      drain();

      // Output stall with continuous input.
      load_cfg(5'd0, 1'b0);
      expect_word(32'h83828180, 1'b0);
      expect_word(32'h87868584, 1'b0);
      expect_word(32'h8B8A8988, 1'b0);
      ofmap_ready = 1'b0;
      fork
         for (int i = 0; i < 12; i++) send(32'(i), 1'b0);
         begin
            int t = 0;
            @(negedge clk);
            while (!ofmap_valid && t < 50) begin
               @(negedge clk);
               t++;
            end
            chk("stall_first_word", ofmap, 32'h83828180);
            repeat (5) begin
               @(negedge clk);
               chk("stall_hold_word", ofmap, 32'h83828180);
               chk("stall_hold_valid", {31'b0, ofmap_valid}, 32'd1);
               chk("stall_opsum_ready", {31'b0, opsum_ready}, 32'd0);
            end
            @(posedge clk);
            #1 ofmap_ready = 1'b1;
         end
      join
      drain();

      // cfg_load in FILL ignored; in IDLE honoured.
      load_cfg(5'd0, 1'b0);
      expect_word(32'h93929190, 1'b0);
      send(32'd16, 1'b0);
      send(32'd17, 1'b0);
      cfg_shift = 5'd3;
      cfg_load  = 1'b1;
      @(posedge clk);
      #1 cfg_load = 1'b0;
      send(32'd18, 1'b0);
      send(32'd19, 1'b0);
      drain();
      load_cfg(5'd3, 1'b0);
      expect_word(32'h8D7E8282, 1'b0);
      send(32'd16, 1'b0);
      send(32'd17, 1'b0);
      send(-32'sd16, 1'b0);
      send(32'd100, 1'b0);
      drain();

      // Reset mid-word: outputs reset at once, config back to shift 0.
      send(32'd50, 1'b0);
      send(32'd60, 1'b0);
      rst = 1'b0;
      #1;
      chk("midrst_opsum_ready", {31'b0, opsum_ready}, 32'd1);
      chk("midrst_ofmap_valid", {31'b0, ofmap_valid}, 32'd0);
      chk("midrst_ofmap_last",  {31'b0, ofmap_last},  32'd0);
      chk("midrst_ofmap",       ofmap,                32'h80808080);
      @(posedge clk);
      #1 rst = 1'b1;
      expect_word(32'h7F7E7D7C, 1'b0);
      send(-32'sd4, 1'b0);
      send(-32'sd3, 1'b0);
      send(-32'sd2, 1'b0);
      send(-32'sd1, 1'b0);
      drain();

      // Back-to-back burst with ready held high: no input wait cycles.
      load_cfg(5'd3, 1'b0);
      w0 = waits;
      expect_word(32'h83828180, 1'b0);
      expect_word(32'hE47D7E7F, 1'b0);
      send(32'd0, 1'b0);
      send(32'd8, 1'b0);
      send(32'd16, 1'b0);
      send(32'd24, 1'b0);
      send(-32'sd8, 1'b0);
      send(-32'sd16, 1'b0);
      send(-32'sd24, 1'b0);
      send(32'd800, 1'b0);
      chk("burst_wait_cycles", 32'(waits - w0), 32'd0);
      drain();

      chk("scoreboard_empty", 32'(sb.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

endmodule
